// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : deserializer
//  Purpose  : Collects N_SAMPLES consecutive BIT_WIDTH-bit words from a
//             val/rdy stream and presents them as one flat frame on a
//             val/rdy output. Word k of a frame is placed at
//             send_msg[BIT_WIDTH*k +: BIT_WIDTH].
//  Ports    :
//     clk       in   1                    rising-edge clock
//     reset     in   1                    synchronous, active-low reset
//     recv_msg  in   BIT_WIDTH            incoming serial word
//     recv_val  in   1                    recv_msg valid
//     recv_rdy  out  1                    word can be accepted this cycle
//     send_msg  out  BIT_WIDTH*N_SAMPLES  assembled frame
//     send_val  out  1                    frame valid
//     send_rdy  in   1                    downstream accepts the frame
//  Revision : 1.0 - initial release
// ============================================================================
module deserializer #(
   parameter int BIT_WIDTH = 32,
   parameter int N_SAMPLES = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [BIT_WIDTH-1:0]           recv_msg,
   input  logic                           recv_val,
   output logic                           recv_rdy,
   output logic [BIT_WIDTH*N_SAMPLES-1:0] send_msg,
   output logic                           send_val,
   input  logic                           send_rdy
);

   localparam int CNT_W = $clog2(N_SAMPLES);

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_next;
   logic                 recv_xfer;
   logic                 cnt_last;
   logic [BIT_WIDTH-1:0] slot [N_SAMPLES];

   assign cnt_last = (cnt == CNT_W'(N_SAMPLES - 1));

   // ------------------------------------------------------------------
   // State and index registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= COLLECT;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output decode. Ready/valid depend only on state,
   // never on the partner's val, so no combinational loop can form.
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      recv_rdy   = 1'b0;
      send_val   = 1'b0;
      recv_xfer  = 1'b0;
      case (state)
         COLLECT: begin
            recv_rdy  = 1'b1;
            recv_xfer = recv_val;
            if (recv_val) begin
               if (cnt_last) begin
                  cnt_next   = '0;
                  state_next = HOLD;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            send_val = 1'b1;
            if (send_rdy) begin
               state_next = COLLECT;
            end
         end
         default: begin
            state_next = COLLECT;
            cnt_next   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Frame storage: one register per slot, written only when the
   // current index selects it. Slots keep their previous-frame value
   // until overwritten; the output is taken straight from these
   // registers so there is no path from recv_msg to send_msg.
   // ------------------------------------------------------------------
   for (genvar k = 0; k < N_SAMPLES; k++) begin : g_slot
      always_ff @(posedge clk) begin
         if (!reset) begin
            slot[k] <= '0;
         end else if (recv_xfer && (cnt == CNT_W'(k))) begin
            slot[k] <= recv_msg;
         end
      end
      assign send_msg[BIT_WIDTH*k +: BIT_WIDTH] = slot[k];
   end

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_deserializer
//  Purpose  : Self-checking bench for deserializer. One instance uses the
//             default 32/8 geometry, a second uses 8/4 for the handshake,
//             back-pressure, bubble, reset and randomized frame checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_deserializer;

   logic         clk;

   // default geometry instance (32-bit words, 8 per frame)
   logic         a_reset;
   logic [31:0]  a_recv_msg;
   logic         a_recv_val;
   logic         a_recv_rdy;
   logic [255:0] a_send_msg;
   logic         a_send_val;
   logic         a_send_rdy;

   // small geometry instance (8-bit words, 4 per frame)
   logic         b_reset;
   logic [7:0]   b_recv_msg;
   logic         b_recv_val;
   logic         b_recv_rdy;
   logic [31:0]  b_send_msg;
   logic         b_send_val;
   logic         b_send_rdy;

   int n_checks = 0;
   int n_fail   = 0;

   // words accepted into the frame currently being assembled (model)
   logic [7:0] pend[$];
   logic [7:0] seq_word;
   int         rise_cyc[$];

   deserializer #(.BIT_WIDTH(32), .N_SAMPLES(8)) u_dut_a (
      .clk      (clk),
      .reset    (a_reset),
      .recv_msg (a_recv_msg),
      .recv_val (a_recv_val),
      .recv_rdy (a_recv_rdy),
      .send_msg (a_send_msg),
      .send_val (a_send_val),
      .send_rdy (a_send_rdy)
   );

   deserializer #(.BIT_WIDTH(8), .N_SAMPLES(4)) u_dut_b (
      .clk      (clk),
      .reset    (b_reset),
      .recv_msg (b_recv_msg),
      .recv_val (b_recv_val),
      .recv_rdy (b_recv_rdy),
      .send_msg (b_send_msg),
      .send_val (b_send_val),
      .send_rdy (b_send_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        val;
      logic [7:0]  msg;
      logic        srdy;
      logic        e_rdy;
      logic        e_sval;
      logic        chk_msg;
      logic [31:0] e_msg;
   } vec_t;

   vec_t vecs[24];

   function automatic vec_t mk(input logic rst_n, input logic val, input logic [7:0] msg,
                               input logic srdy, input logic e_rdy, input logic e_sval,
                               input logic chk_msg, input logic [31:0] e_msg);
      vec_t v;
      v.rst_n   = rst_n;
      v.val     = val;
      v.msg     = msg;
      v.srdy    = srdy;
      v.e_rdy   = e_rdy;
      v.e_sval  = e_sval;
      v.chk_msg = chk_msg;
      v.e_msg   = e_msg;
      return v;
   endfunction

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // apply inputs to the 8/4 instance, then sample just after the edge
   task automatic b_step(input logic rst_n, input logic val, input logic [7:0] msg, input logic srdy);
      b_reset    = rst_n;
      b_recv_val = val;
      b_recv_msg = msg;
      b_send_rdy = srdy;
      @(posedge clk);
      #1;
   endtask

   task automatic b_do_reset();
      b_step(1'b0, 1'b0, 8'h00, 1'b0);
      pend.delete();
   endtask

   // Reference model: a queue of accepted words. While fewer than four
   // are held a word is accepted whenever it is valid; with four held the
   // frame is offered and leaves when the consumer is ready.
   task automatic run_model(input int cycles, input bit stream, input string tag);
      logic        v;
      logic [7:0]  m;
      logic        s;
      logic [31:0] ef;
      bit          full;
      for (int c = 0; c < cycles; c++) begin
         v = stream ? 1'b1 : ($urandom_range(0, 3) != 0);
         m = stream ? seq_word : 8'($urandom);
         s = stream ? 1'b1 : ($urandom_range(0, 2) != 0);
         full = (pend.size() == 4);
         if (!full && v) begin
            pend.push_back(m);
            seq_word = seq_word + 8'd1;
         end else if (full && s) begin
            pend.delete();
         end
         b_step(1'b1, v, m, s);
         check($sformatf("%s_c%0d_rdy", tag, c), 256'(b_recv_rdy), 256'(pend.size() < 4));
         check($sformatf("%s_c%0d_val", tag, c), 256'(b_send_val), 256'(pend.size() == 4));
         if (pend.size() == 4) begin
            ef = '0;
            for (int k = 0; k < 4; k++) ef[8*k +: 8] = pend[k];
            check($sformatf("%s_c%0d_msg", tag, c), 256'(b_send_msg), 256'(ef));
         end
         if (b_send_val) rise_cyc.push_back(c);
      end
   endtask

   initial begin
      logic [255:0] exp_a;
      logic [31:0]  lo_word;
      logic [31:0]  hi_word;

      a_reset = 1'b0; a_recv_val = 1'b0; a_recv_msg = '0; a_send_rdy = 1'b0;
      b_reset = 1'b0; b_recv_val = 1'b0; b_recv_msg = '0; b_send_rdy = 1'b0;
      seq_word = 8'h01;

      // ---------------- basic frame on the 32/8 instance ----------------
      @(posedge clk); #1;
      check("a_reset_rdy", 256'(a_recv_rdy), 256'(1));
      check("a_reset_val", 256'(a_send_val), 256'(0));
      check("a_reset_msg", a_send_msg, 256'(0));
      a_reset = 1'b1;
      exp_a   = '0;
      for (int w = 1; w <= 8; w++) begin
         a_recv_val = 1'b1;
         a_recv_msg = 32'(w);
         a_send_rdy = 1'b1;
         exp_a[32*(w-1) +: 32] = 32'(w);
         @(posedge clk); #1;
         if (w < 8) begin
            check($sformatf("a_w%0d_val", w), 256'(a_send_val), 256'(0));
            check($sformatf("a_w%0d_rdy", w), 256'(a_recv_rdy), 256'(1));
         end
      end
      check("a_frame_val", 256'(a_send_val), 256'(1));
      check("a_frame_rdy", 256'(a_recv_rdy), 256'(0));
      check("a_frame_msg", a_send_msg, exp_a);
      lo_word = a_send_msg[31:0];
      hi_word = a_send_msg[255:224];
      check("a_frame_lo", 256'(lo_word), 256'(32'h1));
      check("a_frame_hi", 256'(hi_word), 256'(32'h8));
      a_recv_val = 1'b0;
      @(posedge clk); #1;
      check("a_after_val", 256'(a_send_val), 256'(0));
      check("a_after_rdy", 256'(a_recv_rdy), 256'(1));

      // ---------------- bubbles + back-pressure vectors (8/4) ----------------
      vecs[0]  = mk(0, 0, 8'h00, 1, 1, 0, 1, 32'h0);
      vecs[1]  = mk(1, 1, 8'h11, 1, 1, 0, 0, 32'h0);
      vecs[2]  = mk(1, 0, 8'h00, 1, 1, 0, 0, 32'h0);
      vecs[3]  = mk(1, 0, 8'h00, 1, 1, 0, 0, 32'h0);
      vecs[4]  = mk(1, 1, 8'h22, 1, 1, 0, 0, 32'h0);
      vecs[5]  = mk(1, 0, 8'h00, 1, 1, 0, 0, 32'h0);
      vecs[6]  = mk(1, 1, 8'h33, 1, 1, 0, 0, 32'h0);
      vecs[7]  = mk(1, 1, 8'h44, 1, 0, 1, 1, 32'h44332211);
      vecs[8]  = mk(1, 0, 8'h00, 1, 1, 0, 0, 32'h0);
      vecs[9]  = mk(1, 1, 8'hA1, 0, 1, 0, 0, 32'h0);
      vecs[10] = mk(1, 1, 8'hB2, 0, 1, 0, 0, 32'h0);
      vecs[11] = mk(1, 1, 8'hC3, 0, 1, 0, 0, 32'h0);
      vecs[12] = mk(1, 1, 8'hD4, 0, 0, 1, 1, 32'hD4C3B2A1);
      for (int i = 13; i <= 17; i++) vecs[i] = mk(1, 1, 8'hEE, 0, 0, 1, 1, 32'hD4C3B2A1);
      vecs[18] = mk(1, 1, 8'hEE, 1, 1, 0, 0, 32'h0);
      vecs[19] = mk(1, 1, 8'hEE, 0, 1, 0, 0, 32'h0);
      vecs[20] = mk(1, 1, 8'h01, 0, 1, 0, 0, 32'h0);
      vecs[21] = mk(1, 1, 8'h02, 0, 1, 0, 0, 32'h0);
      vecs[22] = mk(1, 1, 8'h03, 0, 0, 1, 1, 32'h030201EE);
      vecs[23] = mk(1, 0, 8'h00, 1, 1, 0, 0, 32'h0);

      for (int i = 0; i < 24; i++) begin
         b_step(vecs[i].rst_n, vecs[i].val, vecs[i].msg, vecs[i].srdy);
         check($sformatf("vec%0d_rdy", i), 256'(b_recv_rdy), 256'(vecs[i].e_rdy));
         check($sformatf("vec%0d_val", i), 256'(b_send_val), 256'(vecs[i].e_sval));
         if (vecs[i].chk_msg)
            check($sformatf("vec%0d_msg", i), 256'(b_send_msg), 256'(vecs[i].e_msg));
      end

      // ---------------- back-to-back frames ----------------
      b_do_reset();
      seq_word = 8'h01;
      rise_cyc.delete();
      run_model(15, 1'b1, "b2b");
      check("b2b_frames", 256'(rise_cyc.size()), 256'(3));
      if (rise_cyc.size() >= 3) begin
         check("b2b_period1", 256'(rise_cyc[1] - rise_cyc[0]), 256'(5));
         check("b2b_period2", 256'(rise_cyc[2] - rise_cyc[1]), 256'(5));
      end

      // ---------------- reset mid-frame ----------------
      b_do_reset();
      b_step(1, 1, 8'hAA, 1);
      b_step(1, 1, 8'hBB, 1);
      b_step(0, 1, 8'hCC, 1);
      check("rstmid_rdy", 256'(b_recv_rdy), 256'(1));
      check("rstmid_val", 256'(b_send_val), 256'(0));
      check("rstmid_msg", 256'(b_send_msg), 256'(0));
      for (int w = 1; w <= 4; w++) b_step(1, 1, 8'(w), 1);
      check("rstmid_frame_val", 256'(b_send_val), 256'(1));
      check("rstmid_frame_msg", 256'(b_send_msg), 256'(32'h04030201));
      b_step(1, 0, 8'h00, 1);
      check("rstmid_done_val", 256'(b_send_val), 256'(0));

      // ---------------- reset during HOLD ----------------
      for (int w = 5; w <= 8; w++) b_step(1, 1, 8'(w), 0);
      b_step(1, 0, 8'h00, 0);
      check("rsthold_pre_val", 256'(b_send_val), 256'(1));
      check("rsthold_pre_msg", 256'(b_send_msg), 256'(32'h08070605));
      b_step(0, 1, 8'h09, 0);
      check("rsthold_val", 256'(b_send_val), 256'(0));
      check("rsthold_msg", 256'(b_send_msg), 256'(0));
      check("rsthold_rdy", 256'(b_recv_rdy), 256'(1));

      // ---------------- randomized traffic against the model ----------------
      b_do_reset();
      run_model(400, 1'b0, "rnd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the sample serializer.
- Collects N_SAMPLES consecutive BIT_WIDTH-bit words over a val/rdy stream and presents them as one flat N_SAMPLES*BIT_WIDTH frame on a val/rdy output.
- Sits between the serial link and downstream frame consumers (e.g. FFT input).
- Word k of a frame lands in send_msg[BIT_WIDTH*k +: BIT_WIDTH], the inverse of the serializer's sample ordering.

Parameters:
- BIT_WIDTH, 32, width of one serial word/sample.
- N_SAMPLES, 8, words per frame; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 clears state at next rising clk edge)
- recv_msg  input  BIT_WIDTH  incoming serial word
- recv_val  input  1  recv_msg valid
- recv_rdy  output  1  block can accept a word this cycle
- send_msg  output  BIT_WIDTH*N_SAMPLES  assembled frame, word k at bits [BIT_WIDTH*k +: BIT_WIDTH]
- send_val  output  1  frame valid
- send_rdy  input  1  downstream accepts frame

Behaviour:
- Handshake: a transfer occurs on a cycle where val && rdy at the rising edge. rdy must not depend combinationally on val, on either side.
- State machine, two states:
  - COLLECT: recv_rdy=1, send_val=0.
  - HOLD: recv_rdy=0, send_val=1.
- Index counter cnt, width $clog2(N_SAMPLES), counts 0..N_SAMPLES-1.
- Reset (reset==0 at an edge):
  - state=COLLECT, cnt=0, frame register cleared to all zeros.
  - Outputs after reset: recv_rdy=1, send_val=0, send_msg=0.
  - Reset overrides any in-flight handshake on that cycle; a partial frame is discarded.
- COLLECT:
  - On a recv transfer, write recv_msg into slot cnt.
  - If cnt==N_SAMPLES-1: cnt wraps to 0 and state goes to HOLD.
  - Otherwise cnt increments.
  - recv_val=0: no change. Gaps between words are allowed at any position.
- HOLD:
  - send_msg is stable and equal to the full frame; send_val=1.
  - On send_rdy=1: go to COLLECT next cycle. recv_rdy returns to 1 on the following cycle.
  - On send_rdy=0: remain in HOLD; send_msg and send_val stay constant indefinitely (no drop, no overwrite).
  - recv_val is ignored; recv_rdy=0, so words are back-pressured, not lost.
- send_msg is driven directly from the frame register (registered output, no combinational path from recv_msg).
- Slots not yet rewritten in the current frame keep their previous-frame value. Only send_msg while send_val=1 is defined content.
- Latency:
  - Last word accepted at edge t, so send_val=1 from cycle t+1.
  - Minimum frame period is N_SAMPLES+1 cycles (N_SAMPLES accept cycles plus 1 HOLD cycle with send_rdy=1).
- No simultaneous recv and send transfers occur, because recv_rdy and send_val are mutually exclusive.
- Implementation target: one state register, one counter, N_SAMPLES word registers with per-slot write enable decoded from cnt.

Test Plan:
1. Basic frame, defaults (32/8), send_rdy=1, recv_val=1 continuous.
   - Stimulus: words 0x00000001..0x00000008.
   - Required: send_val rises the cycle after word 8 accepted; send_msg[31:0]=0x1 and send_msg[255:224]=0x8; send_val lasts exactly 1 cycle; recv_rdy=0 that cycle, 1 the next.
2. Back-pressure, BIT_WIDTH=8, N_SAMPLES=4, send_rdy=0 for 5 cycles after frame complete.
   - Stimulus: words 0xA1,0xB2,0xC3,0xD4; recv_val held high with 0xEE throughout HOLD.
   - Required: send_msg=0xD4C3B2A1 stable all 5 cycles; recv_rdy=0; after send_rdy=1 the next frame's slot 0 receives 0xEE.
3. Bubbles, 8/4.
   - Stimulus: recv_val pattern 1,0,0,1,0,1,1 with words 0x11,0x22,0x33,0x44 on valid cycles.
   - Required: frame 0x44332211; send_val only after the 4th valid.
4. Back-to-back, 8/4.
   - Stimulus: 3 frames streamed with send_rdy=1.
   - Required: each frame correct, no word lost or duplicated, frame period 5 cycles.
5. Reset mid-frame.
   - Stimulus: 2 words accepted, then reset=0 for 1 cycle, then 4 new words 0x01..0x04.
   - Required: output frame 0x04030201; no stale words; send_val=0 and recv_rdy=1 immediately after reset.
6. Reset during HOLD with send_rdy=0.
   - Required: next cycle send_val=0, send_msg=0, recv_rdy=1.
